demux_1_4_reg: RTL and testbench
================================

Name: demux_1_4_reg

Overview:
- Registered 1:4 demultiplexer. It is the distribution-side counterpart of the team's 2:1/4:1 data muxes.
- Accepts one W-bit word per handshake on a single input stream and routes it, by a 2-bit select, into one of four independent output channels.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Used wherever one producer feeds four consumers that can each stall independently.

Parameters:
- W, 4, data width of input and each output channel.
- CW, 8, width of the wrapping transfer counter.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, input word present.
- in_sel, input, 2, destination channel for the current input word (0..3).
- in_data, input, W, input word.
- in_ready, output, 1, block can accept the current input word this cycle.
- out_valid, output, 4, bit i set means channel i holds a word.
- out_ready, input, 4, bit i set means consumer i takes the word this cycle.
- out_data0, output, W, channel 0 held word.
- out_data1, output, W, channel 1 held word.
- out_data2, output, W, channel 2 held word.
- out_data3, output, W, channel 3 held word.
- xfer_cnt, output, CW, count of accepted input words, wraps modulo 2^CW.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=4'b0000.
  - out_data0..3 = 0.
  - xfer_cnt = 0.
  - Any held words are discarded, including reset mid-stall.
  - No transfer is counted in a reset cycle, even if in_valid=1.
- Input accept:
  - accept = in_valid & in_ready.
  - in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - in_ready is combinational from in_sel, out_valid and out_ready. It does not depend on in_valid.
  - in_ready reflects only the selected channel; a full, stalled non-selected channel does not block.
- Output drain: channel i drains when out_valid[i] & out_ready[i].
- Per-channel next state, with ld_i = accept & (in_sel==i):
  - ld_i=1: out_data_i <= in_data and out_valid[i] <= 1. This holds even if channel i drains in the same cycle (simultaneous drain+load keeps valid high with the new word, no bubble).
  - ld_i=0 and drain_i=1: out_valid[i] <= 0. out_data_i keeps its last value (don't-care to consumers).
  - Otherwise: hold.
- Latency: a word accepted at edge N appears on out_data_{sel} with out_valid set after edge N. One cycle, no combinational path from in_data to outputs.
- Stall:
  - While out_valid[i]=1 and out_ready[i]=0, out_data_i is stable.
  - A new word to channel i is refused (in_ready=0 when in_sel=i).
- Ordering: words to the same channel are delivered in acceptance order. No cross-channel ordering is implied.
- out_ready[i] while out_valid[i]=0 has no effect.
- At most one channel loads per cycle. Any number of channels may drain in the same cycle.
- xfer_cnt increments by 1 on every accept.
  - Wraps from 2^CW-1 to 0.
  - Unaffected by drains.
- Unused: in_sel and in_data values while in_valid=0 have no effect on state.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with in_valid=1 and out_ready=4'hF -> out_valid=0, out_data0..3=0, xfer_cnt=0, in_ready=1.
- Basic routing, all out_ready=1:
  - Stimulus: sel=0,d=4'h1; sel=1,d=4'h2; sel=2,d=4'h3; sel=3,d=4'h4 on consecutive cycles.
  - Response: each word appears exactly one cycle later on the matching channel with a one-cycle out_valid pulse; xfer_cnt=4.
- Back-pressure isolation:
  - Stimulus: out_ready=4'b1110; send sel=0 d=4'hA, then sel=0 d=4'hB, then sel=1 d=4'hC.
  - Response: out_data0=A held and out_valid[0]=1; the second sel=0 word sees in_ready=0 and is not counted; the sel=1 word is accepted the same cycle (in_ready=1).
- Simultaneous drain+load:
  - Stimulus: channel 2 holds 4'h5; in one cycle out_ready[2]=1 and accept sel=2 d=4'h6.
  - Response: the next cycle has out_valid[2]=1 and out_data2=6, with no gap cycle.
- Counter wrap (CW=8): perform 257 accepts -> xfer_cnt=1.
- Reset mid-stall:
  - Stimulus: channels 0 and 3 hold data with out_ready=0; pulse rst=1 for one cycle.
  - Response: out_valid=0, out_data0 and out_data3=0, xfer_cnt=0; the next sel=3 accept works normally.

Source files
------------

// File: rtl/demux_1_4_reg.sv
// rtl/demux_1_4_reg.sv - registered 1:4 stream demux with per-channel one-entry holding registers
module demux_1_4_reg #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [1:0]    in_sel,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [W-1:0]  out_data0,
  output logic [W-1:0]  out_data1,
  output logic [W-1:0]  out_data2,
  output logic [W-1:0]  out_data3,
  output logic [CW-1:0] xfer_cnt
);

  logic [3:0]    out_valid_q, out_valid_d;
  logic [W-1:0]  data_q [4];
  logic [W-1:0]  data_d [4];
  logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;

  logic          accept;
  logic [3:0]    ld;
  logic [3:0]    drain;

  // Only the selected channel gates acceptance; other stalled channels never block.
  always_comb begin
    in_ready = ~out_valid_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
  end

  always_comb begin
    ld    = 4'b0000;
    drain = out_valid_q & out_ready;
    for (int i = 0; i < 4; i++) begin
      ld[i] = accept & (in_sel == 2'(i));
    end
  end

  // Load wins over drain so a simultaneous drain+load keeps the channel full.
  always_comb begin
    out_valid_d = out_valid_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      if (ld[i]) begin
        data_d[i]      = in_data;
        out_valid_d[i] = 1'b1;
      end else if (drain[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (accept) begin
      xfer_cnt_d = xfer_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 4'b0000;
      xfer_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_demux_1_4_reg.sv
// tb/tb_demux_1_4_reg.sv - randomized and directed bench for demux_1_4_reg against a queue-based model
module tb_demux_1_4_reg;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [CW-1:0] xfer_cnt;

  demux_1_4_reg #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference: each channel is a queue of capacity one; last_word is what the register shows.
  logic [W-1:0] chan_q [4][$];
  logic [W-1:0] last_word [4];
  int           exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic [1:0] sel, input logic [3:0] rdy);
    return (chan_q[sel].size() == 0) || rdy[sel];
  endfunction

  task automatic check_outputs();
    logic [W-1:0] seen [4];
    seen[0] = out_data0;
    seen[1] = out_data1;
    seen[2] = out_data2;
    seen[3] = out_data3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(chan_q[i].size() != 0));
      check($sformatf("out_data%0d", i), 32'(seen[i]), 32'(last_word[i]));
    end
    check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  // One clock of stimulus: drive after the falling edge, check in_ready, advance model at the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [W-1:0] d, input logic [3:0] rdy);
    logic exp_rdy;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_rdy = model_ready(s, rdy);
    if (!r) check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        chan_q[i].delete();
        last_word[i] = '0;
      end
      exp_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (chan_q[i].size() != 0 && rdy[i]) void'(chan_q[i].pop_front());
      end
      if (v && exp_rdy) begin
        chan_q[s].push_back(d);
        last_word[s] = d;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic [3:0] rdy);
    step(1'b0, 1'b0, 2'(0), 4'h0, rdy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) last_word[i] = '0;

    // Reset with traffic present must count nothing.
    step(1'b1, 1'b1, 2'd2, 4'h9, 4'hF);
    step(1'b1, 1'b1, 2'd1, 4'h7, 4'hF);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset xfer_cnt", 32'(xfer_cnt), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);

    // Basic routing.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 4'(i + 1), 4'hF);
    check("route xfer_cnt", 32'(xfer_cnt), 32'd4);
    check("route ch3", 32'(out_data3), 32'h4);
    idle(4'hF);

    // Back-pressure isolation on channel 0.
    step(1'b0, 1'b1, 2'd0, 4'hA, 4'b1110);
    step(1'b0, 1'b1, 2'd0, 4'hB, 4'b1110);
    check("bp refused", 32'(xfer_cnt), 32'd5);
    step(1'b0, 1'b1, 2'd1, 4'hC, 4'b1110);
    check("bp held ch0", 32'(out_data0), 32'hA);
    check("bp cnt", 32'(xfer_cnt), 32'd6);
    idle(4'hF);

    // Simultaneous drain and load on channel 2.
    step(1'b0, 1'b1, 2'd2, 4'h5, 4'b0000);
    step(1'b0, 1'b1, 2'd2, 4'h6, 4'b0100);
    check("dl valid2", 32'(out_valid[2]), 32'h1);
    check("dl data2", 32'(out_data2), 32'h6);
    idle(4'hF);

    // Counter wrap from a fresh reset.
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'hF);
    for (int i = 0; i < 257; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 4'hF);
    check("wrap xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Reset while channels 0 and 3 stall.
    step(1'b0, 1'b1, 2'd0, 4'h7, 4'h0);
    step(1'b0, 1'b1, 2'd3, 4'h9, 4'h0);
    step(1'b1, 1'b1, 2'd3, 4'h3, 4'h0);
    check("mid rst valid", 32'(out_valid), 32'h0);
    check("mid rst data0", 32'(out_data0), 32'h0);
    check("mid rst data3", 32'(out_data3), 32'h0);
    step(1'b0, 1'b1, 2'd3, 4'hE, 4'h0);
    check("post rst data3", 32'(out_data3), 32'hE);
    check("post rst cnt", 32'(xfer_cnt), 32'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
